ifns_encoder_7_iter: RTL and testbench

Iterative Fibonacci-numeral-system encoder: maps a 5-bit data word to a 7-bit crosstalk-avoidance codeword d7..d1, one weight per cycle.
- Transmit-side counterpart of the 7-bit IFNS decoder. That decoder recovers data as the weighted sum of set code bits.
- Sits between the data source and the bus driver.
- Valid/ready handshake on both sides.

---
 rtl/ifns_pkg.sv | 31 +++
 rtl/ifns_fns_step.sv | 18 +
 rtl/ifns_encoder_7_iter.sv | 111 +++++++++++
 tb/tb_ifns_encoder_7_iter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifns_pkg.sv
// Shared constants, weight table and state type for the 7-bit Fibonacci
// numeral system (IFNS) encoder.
package ifns_pkg;

  localparam int DATA_W = 5;
  localparam int CODE_W = 7;

  // Weight of code bit dk, indexed [7:1]; W[7] is the most significant.
  localparam logic [CODE_W:1][DATA_W-1:0] IFNS7_W = {
    5'd13, 5'd8, 5'd5, 5'd3, 5'd2, 5'd1, 5'd1
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } ifns_state_e;

  // Weight lookup that returns 0 for the unused index 0.
  function automatic logic [DATA_W-1:0] ifns7_weight(input logic [2:0] k);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 1; i <= CODE_W; i++) begin
      if (k == 3'(i)) begin
        w = IFNS7_W[i];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ifns_fns_step.sv
// One greedy Fibonacci step: take the weight out of the remainder when it
// fits and report whether the corresponding code bit is set.
module ifns_fns_step
  import ifns_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] weight_i,
  output logic              bit_o,
  output logic [DATA_W-1:0] rem_o
);

  logic fits;

  assign fits  = (rem_i >= weight_i);
  assign bit_o = fits;
  assign rem_o = fits ? (rem_i - weight_i) : rem_i;

endmodule

// File: rtl/ifns_encoder_7_iter.sv
// Iterative IFNS encoder: converts a 5-bit word into the 7-bit codeword
// d7..d1 one weight per cycle, with valid/ready handshakes on both sides.
module ifns_encoder_7_iter #(
  parameter int DATA_W = 5,
  parameter int CODE_W = 7
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [CODE_W:1]   codeout,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              busy
);

  import ifns_pkg::*;

  if (DATA_W != ifns_pkg::DATA_W) begin : g_bad_data_w
    $error("ifns_encoder_7_iter: DATA_W must be %0d", ifns_pkg::DATA_W);
  end
  if (CODE_W != ifns_pkg::CODE_W) begin : g_bad_code_w
    $error("ifns_encoder_7_iter: CODE_W must be %0d", ifns_pkg::CODE_W);
  end

  localparam logic [2:0] K_TOP = 3'(CODE_W);

  ifns_state_e       state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [2:0]        k_q, k_d;
  logic [CODE_W:1]   work_q, work_d;
  logic [CODE_W:1]   codeout_q, codeout_d;

  logic [DATA_W-1:0] step_weight;
  logic [DATA_W-1:0] step_rem;
  logic              step_bit;
  logic [CODE_W:1]   work_step;

  assign step_weight = ifns7_weight(k_q);

  ifns_fns_step u_step (
    .rem_i    (rem_q),
    .weight_i (step_weight),
    .bit_o    (step_bit),
    .rem_o    (step_rem)
  );

  // Partial codeword with the bit decided this cycle merged in at position k.
  for (genvar gi = 1; gi <= CODE_W; gi++) begin : g_work
    assign work_step[gi] = (k_q == 3'(gi)) ? step_bit : work_q[gi];
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    k_d       = k_q;
    work_d    = work_q;
    codeout_d = codeout_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          rem_d   = datain;
          work_d  = '0;
          k_d     = K_TOP;
          state_d = CONV;
        end
      end
      CONV: begin
        rem_d  = step_rem;
        work_d = work_step;
        k_d    = k_q - 3'd1;
        if (k_q == 3'd1) begin
          codeout_d = work_step;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (code_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      k_q       <= '0;
      work_q    <= '0;
      codeout_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      k_q       <= k_d;
      work_q    <= work_d;
      codeout_q <= codeout_d;
    end
  end

  // Handshake flags decode straight from the state so reset clears them at once.
  assign din_ready  = (state_q == IDLE);
  assign code_valid = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign codeout    = codeout_q;

endmodule

// File: tb/tb_ifns_encoder_7_iter.sv
// Self-checking bench for ifns_encoder_7_iter: directed vectors, back-to-back
// sweep, back-pressure, mid-conversion reset and randomized handshakes.
module tb_ifns_encoder_7_iter;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [4:0] datain;
  logic       din_valid;
  logic       din_ready;
  logic [7:1] codeout;
  logic       code_valid;
  logic       code_ready;
  logic       busy;

  ifns_encoder_7_iter dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .datain     (datain),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .codeout    (codeout),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int wt [8] = '{0, 1, 1, 2, 3, 5, 8, 13};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Greedy Fibonacci representation from the largest weight down.
  function automatic logic [7:1] fib_encode(input int v);
    logic [7:1] c;
    int r;
    c = '0;
    r = v;
    for (int k = 7; k >= 1; k--) begin
      if (r >= wt[k]) begin
        c[k] = 1'b1;
        r -= wt[k];
      end
    end
    return c;
  endfunction

  function automatic int fib_decode(input logic [7:1] c);
    int s;
    s = 0;
    for (int k = 1; k <= 7; k++) begin
      if (c[k]) s += wt[k];
    end
    return s;
  endfunction

  // Scoreboard state: words accepted but not yet delivered, plus timing.
  int unsigned cyc = 0;
  logic [4:0]  exp_q [$];
  int unsigned acc_edge = 0;
  int unsigned prev_acc = 0;
  bit          have_prev = 0;
  bit          per_en = 0;
  bit          in_flight = 0;
  logic [7:1]  last_code = '0;
  int          n_in = 0;
  int          n_out = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    logic [4:0] d;
    if (!rst_n) begin
      check("rst_code_valid", code_valid, 1'b0);
      check("rst_codeout", codeout, 7'h00);
      check("rst_busy", busy, 1'b0);
      exp_q.delete();
      in_flight = 0;
      last_code = '0;
      have_prev = 0;
      n_in = 0;
      n_out = 0;
    end else begin
      check("din_ready", din_ready, !in_flight);
      check("busy", busy, in_flight);
      check("code_valid", code_valid, in_flight && (cyc - acc_edge >= 7));
      if (code_valid) begin
        check("queue_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("codeout", codeout, fib_encode(int'(exp_q[0])));
      end else begin
        check("codeout_hold", codeout, last_code);
      end
      if (code_valid && code_ready && exp_q.size() > 0) begin
        d = exp_q.pop_front();
        check("wsum", fib_decode(codeout), d);
        $display("txn data=%0d code=%02h", d, codeout);
        last_code = codeout;
        in_flight = 0;
        n_out++;
      end
      if (din_valid && din_ready) begin
        exp_q.push_back(datain);
        in_flight = 1;
        acc_edge = cyc + 1;
        n_in++;
        if (per_en && have_prev) check("period", acc_edge - prev_acc, 9);
        prev_acc = acc_edge;
        have_prev = 1;
      end
    end
  end

  typedef struct {
    logic [4:0] d;
    logic [7:1] code;
    string      nm;
  } vec_t;

  vec_t vecs [7];

  // Called at #1 after a rising edge with the DUT idle.
  task automatic run_vec(input logic [4:0] d, input logic [7:1] exp, input string nm);
    int lat;
    bit seen;
    datain = d;
    din_valid = 1'b1;
    @(posedge clock);
    #1 din_valid = 1'b0;
    seen = 0;
    lat = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (code_valid) begin
        seen = 1;
        lat = n;
      end
    end
    check({"lat_", nm}, lat, 7);
    check(nm, codeout, exp);
    @(posedge clock);
    @(negedge clock);
    check({"ready_back_", nm}, din_ready, 1'b1);
    check({"valid_drop_", nm}, code_valid, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit done;
    din_valid = 1'b0;
    code_ready = 1'b1;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clock);
      done = (n_out == n_in) && din_ready;
    end
    check("drain_count", n_out, n_in);
    check("drain_idle", din_ready, 1'b1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    bit got;

    vecs[0] = '{5'd0,  7'h00, "enc_0"};
    vecs[1] = '{5'd31, 7'h7C, "enc_31"};
    vecs[2] = '{5'd20, 7'h54, "enc_20"};
    vecs[3] = '{5'd12, 7'h2A, "enc_12"};
    vecs[4] = '{5'd7,  7'h14, "enc_7"};
    vecs[5] = '{5'd1,  7'h02, "enc_1"};
    vecs[6] = '{5'd2,  7'h04, "enc_2"};

    rst_n = 1'b1;
    din_valid = 1'b0;
    datain = '0;
    code_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_din_ready", din_ready, 1'b1);
    check("reset_code_valid", code_valid, 1'b0);
    check("reset_codeout", codeout, 7'h00);
    check("reset_busy", busy, 1'b0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i].d, vecs[i].code, vecs[i].nm);

    // Back-to-back sweep with din_valid held high.
    have_prev = 0;
    per_en = 1;
    din_valid = 1'b1;
    for (int v = 0; v < 32; v++) begin
      datain = 5'(v);
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clock);
        got = din_ready;
        @(posedge clock);
        #1;
      end
      check("sweep_accept", got, 1'b1);
    end
    drain();
    per_en = 0;

    // Back-pressure: hold OUT for 20 cycles, poke din_valid in the window.
    code_ready = 1'b0;
    datain = 5'd25;
    din_valid = 1'b1;
    @(posedge clock);
    #1 din_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      got = code_valid;
    end
    check("bp_valid_seen", got, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (i == 5) begin
        din_valid = 1'b1;
        datain = 5'd9;
      end else begin
        din_valid = 1'b0;
      end
      @(negedge clock);
      check("bp_valid", code_valid, 1'b1);
      check("bp_code", codeout, 7'h6A);
    end
    @(posedge clock);
    #1;
    drain();
    check("bp_words", n_in, 40);

    // Asynchronous reset after the fourth conversion step.
    datain = 5'd17;
    din_valid = 1'b1;
    @(posedge clock);
    #1 din_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    check("arst_code_valid", code_valid, 1'b0);
    check("arst_codeout", codeout, 7'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_din_ready", din_ready, 1'b1);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    run_vec(5'd17, 7'h4A, "post_rst_17");

    // Randomized valid/ready traffic.
    target = n_out + 1000;
    for (int c = 0; c < 40000 && n_out < target; c++) begin
      @(posedge clock);
      #1;
      din_valid  = ($urandom_range(0, 1) == 1);
      datain     = 5'($urandom_range(0, 31));
      code_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_words", (n_out >= target), 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
